up_down_counter: RTL and testbench

UP_DOWN_COUNTER -- requirements
Module: up_down_counter

---
 rtl/up_down_counter_if.sv | 13 +
 rtl/up_down_counter.sv | 29 ++
 tb/tb_up_down_counter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/up_down_counter_if.sv
// Bundles the counter's direction control and count output so a driver and the
// counter can be wired through one handle.
interface up_down_counter_if #(
  parameter int WIDTH = 4
) (
  input logic clk
);
  logic             mode;
  logic [WIDTH-1:0] d_out;

  modport master (input clk, output mode, input d_out);
  modport slave  (input clk, input mode, output d_out);
endinterface

// File: rtl/up_down_counter.sv
// Free-running WIDTH-bit up/down counter: mode=0 counts up, mode=1 counts down,
// wrapping modulo 2^WIDTH; async clear, release retimed to the clock.
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             mode,
  output logic [WIDTH-1:0] d_out
);

  logic             run;
  logic [WIDTH-1:0] count;

  // Release passes through run and then the count register itself, so the
  // first count lands on the second rising edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= '0;
    else if (run) count <= mode ? count - WIDTH'(1) : count + WIDTH'(1);
  end

  assign d_out = count;

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter: a modulo-arithmetic model checked every
// cycle, plus literal expected counts for reset, wrap, reversal and mid-run reset.
module tb_up_down_counter;
  localparam int WIDTH = 4;
  localparam int MODV  = 1 << WIDTH;

  logic clk;
  logic rst;

  up_down_counter_if #(.WIDTH(WIDTH)) bus (.clk(clk));

  up_down_counter #(.WIDTH(WIDTH)) dut (
    .rst   (rst),
    .clk   (clk),
    .mode  (bus.mode),
    .d_out (bus.d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: count value and number of edges seen since reset released.
  int m_cnt   = 0;
  int m_since = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   = 0;
      m_since = 0;
    end else begin
      if (m_since >= 1)
        m_cnt = bus.mode ? (m_cnt + MODV - 1) % MODV : (m_cnt + 1) % MODV;
      m_since = m_since + 1;
    end
  end

  // Literal expectations handed from the stimulus to the compare process.
  int    lit_seq  = 0;
  int    lit_val  = 0;
  string lit_name = "";

  initial begin : compare
    int seen;
    seen = 0;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst && clk) begin
        // Reset edge away from the clock: d_out must clear without an edge.
        #1;
        checks++;
        if (bus.d_out !== '0) begin
          errors++;
          $display("FAIL async_clear: d_out=%0d required=0 at %0t", bus.d_out, $time);
        end
      end else if (!clk) begin
        checks++;
        if (bus.d_out !== WIDTH'(m_cnt)) begin
          errors++;
          $display("FAIL model: d_out=%0d required=%0d at %0t", bus.d_out, m_cnt, $time);
        end
        if (lit_seq != seen) begin
          seen = lit_seq;
          checks++;
          if (bus.d_out !== WIDTH'(lit_val)) begin
            errors++;
            $display("FAIL %s: d_out=%0d required=%0d at %0t", lit_name, bus.d_out, lit_val, $time);
          end
        end
      end
    end
  end

  task automatic expect_next(input int v, input string nm);
    @(posedge clk);
    lit_val  = v;
    lit_name = nm;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic mid_cycle_reset();
    #2;
    rst = 1'b0;
    #2;
  endtask

  initial begin : stim
    rst      = 1'b0;
    bus.mode = 1'b0;
    for (int i = 0; i < 3; i++) expect_next(0, "in_reset");

    // Count to 7, then assert reset between edges and hold it.
    rst = 1'b1;
    expect_next(0, "sync_delay");
    for (int v = 1; v <= 7; v++) expect_next(v, "pre_reset_up");
    mid_cycle_reset();
    expect_next(0, "held_reset");
    bus.mode = 1'b1;
    expect_next(0, "held_reset");
    bus.mode = 1'b0;
    expect_next(0, "held_reset");

    // Up count after release, then up wrap from 14.
    rst = 1'b1;
    expect_next(0, "sync_delay");
    for (int v = 1; v <= 5; v++)  expect_next(v, "up_count");
    for (int v = 6; v <= 14; v++) expect_next(v, "up_run");
    expect_next(15, "up_wrap");
    expect_next(0,  "up_wrap");
    expect_next(1,  "up_wrap");

    // Down wrap from 1.
    bus.mode = 1'b1;
    expect_next(0,  "down_wrap");
    expect_next(15, "down_wrap");
    expect_next(14, "down_wrap");

    // Reversal from 5.
    mid_cycle_reset();
    expect_next(0, "held_reset");
    rst      = 1'b1;
    bus.mode = 1'b0;
    expect_next(0, "sync_delay");
    for (int v = 1; v <= 5; v++) expect_next(v, "rev_up");
    bus.mode = 1'b1;
    expect_next(4, "reverse_down");
    expect_next(3, "reverse_down");
    expect_next(2, "reverse_down");
    bus.mode = 1'b0;
    expect_next(3, "reverse_up");

    // Reset mid-run while counting down at 9, then recover counting up.
    for (int v = 4; v <= 10; v++) expect_next(v, "climb");
    bus.mode = 1'b1;
    expect_next(9, "down_to_9");
    mid_cycle_reset();
    expect_next(0, "mid_reset");
    expect_next(0, "mid_reset");
    rst      = 1'b1;
    bus.mode = 1'b0;
    expect_next(0, "sync_delay");
    expect_next(1, "restart_up");

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
